// File: rtl/upsample_stream.sv
`default_nettype none
// ============================================================================
// Module      : upsample_stream
// Description : 2x nearest-neighbour upsampler for a streamed square frame,
//               built around a one-row line buffer and one output register.
// Revision    : 1.0 - initial release
// ============================================================================
module upsample_stream #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 2 * WIDTH_IN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    localparam int                 c_IDX_W    = $clog2(WIDTH_IN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH_OUT / 2 - 1);

    typedef enum logic [0:0] {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_IDX_W-1:0] r_col;
    logic [c_IDX_W-1:0] r_row;
    logic               r_dup;
    logic [31:0]        r_line_buf [WIDTH_IN];
    logic [31:0]        r_out_data;
    logic               r_out_valid;
    logic               r_out_last;

    logic               w_out_free;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_col_last;
    logic               w_row_last;
    logic [31:0]        w_buf_rd;

    assign w_out_free = ~r_out_valid | out_ready;
    assign w_in_ready = ~reset & (r_state == ROW_A) & ~r_dup & w_out_free;
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_col_last = (r_col == c_LAST_IDX);
    assign w_row_last = (r_row == c_LAST_IDX);
    assign w_buf_rd   = r_line_buf[r_col];

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // No reset here: every entry is rewritten by the top row before it is read.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_line_buf[r_col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ROW_A;
            r_col       <= '0;
            r_row       <= '0;
            r_dup       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ROW_A: begin
                    if (!r_dup) begin
                        if (w_in_fire) begin
                            r_out_data  <= in_data;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_dup       <= 1'b1;
                        end else if (w_out_free) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end else if (w_out_free) begin
                        // Second copy comes from the buffer written on the previous edge.
                        r_out_data  <= w_buf_rd;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_dup       <= 1'b0;
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_state <= ROW_B;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ROW_B: begin
                    if (w_out_free) begin
                        r_out_data  <= w_buf_rd;
                        r_out_valid <= 1'b1;
                        r_out_last  <= r_dup & w_col_last & w_row_last;
                        r_dup       <= ~r_dup;
                        if (r_dup) begin
                            if (w_col_last) begin
                                r_col   <= '0;
                                r_state <= ROW_A;
                                r_row   <= w_row_last ? '0 : r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_upsample_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_upsample_stream
// Description : Self-checking bench for upsample_stream (WIDTH_IN = 2 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upsample_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v     = 2'b11;
    logic [1:0]  in_valid  = 2'b00;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready = 2'b11;
    logic [1:0]  out_last;
    logic [31:0] in_data  [2];
    logic [31:0] out_data [2];
    logic [1:0]  hold_rdy = 2'b11;
    logic [1:0]  rnd_rdy  = 2'b00;

    int total = 0;
    int bad   = 0;

    upsample_stream #(.WIDTH_IN(2)) u_dut_w2 (
        .clk(clk), .reset(rst_v[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0])
    );

    upsample_stream #(.WIDTH_IN(4)) u_dut_w4 (
        .clk(clk), .reset(rst_v[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1])
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Frame model: every accepted pixel is kept; output k of a frame maps back
    // to input (r/2, c/2) of the same frame.
    logic [31:0] hist [2][1024];
    int          in_cnt [2];
    int          out_cnt [2];
    int          n_last [2];
    int          cyc = 0;
    logic [1:0]  pend_acc = 2'b00;
    logic [1:0]  pend_stall = 2'b00;
    logic [31:0] pend_data [2];
    logic [31:0] hold_data [2];
    logic [1:0]  hold_last = 2'b00;
    logic [31:0] log_d [$];
    logic        log_l [$];
    int          log_t [$];

    always @(negedge clk) begin
        int w, fsz, j, r, c, idx, n, i;
        cyc = cyc + 1;
        for (int g = 0; g < 2; g++) begin
            w   = (g == 0) ? 2 : 4;
            fsz = 4 * w * w;
            if (rst_v[g]) begin
                in_cnt[g]     = 0;
                out_cnt[g]    = 0;
                n_last[g]     = 0;
                pend_acc[g]   = 1'b0;
                pend_stall[g] = 1'b0;
            end else begin
                if (pend_acc[g]) begin
                    chk("latency_valid", out_valid[g], 1);
                    chk("latency_data", out_data[g], pend_data[g]);
                end
                if (pend_stall[g]) begin
                    chk("hold_valid", out_valid[g], 1);
                    chk("hold_data", out_data[g], hold_data[g]);
                    chk("hold_last", out_last[g], hold_last[g]);
                end
                if (in_ready[g]) begin
                    // Input may only be requested when the next output slot is its first copy.
                    n = out_cnt[g] + (out_valid[g] ? 1 : 0);
                    i = in_cnt[g];
                    chk("ready_slot", n,
                        (i / (w * w)) * fsz + ((i % (w * w)) / w) * 4 * w + (i % w) * 2);
                end
                if (out_valid[g] && out_ready[g]) begin
                    j   = out_cnt[g] % fsz;
                    r   = j / (2 * w);
                    c   = j % (2 * w);
                    idx = (out_cnt[g] / fsz) * w * w + (r / 2) * w + c / 2;
                    chk("pixel", out_data[g], hist[g][idx % 1024]);
                    chk("last", out_last[g], (j == fsz - 1) ? 1 : 0);
                    if (out_last[g]) n_last[g]++;
                    if (g == 0) begin
                        log_d.push_back(out_data[0]);
                        log_l.push_back(out_last[0]);
                        log_t.push_back(cyc);
                    end
                    out_cnt[g]++;
                end
                pend_acc[g] = in_valid[g] & in_ready[g];
                if (pend_acc[g]) begin
                    hist[g][in_cnt[g] % 1024] = in_data[g];
                    pend_data[g] = in_data[g];
                    in_cnt[g]++;
                end
                pend_stall[g] = out_valid[g] & ~out_ready[g];
                hold_data[g]  = out_data[g];
                hold_last[g]  = out_last[g];
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++)
                out_ready[g] = rnd_rdy[g] ? ($urandom_range(0, 3) != 0) : hold_rdy[g];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input int g, input logic [31:0] d, input int gap);
        int   budget;
        logic acc;
        in_valid[g] = 1'b1;
        in_data[g]  = d;
        budget      = 0;
        do begin
            @(negedge clk);
            acc = in_ready[g];
            tick();
            budget++;
        end while (!acc && budget < 300);
        if (!acc) chk("accept_timeout", 0, 1);
        if (gap > 0) begin
            in_valid[g] = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic send_frame(input int g, input int base, input int npx, input int gap);
        for (int k = 0; k < npx; k++) send_px(g, 32'(base + k), gap);
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_out(input int g, input int n);
        int b = 0;
        while (((g == 0) ? log_d.size() : out_cnt[1]) < n && b < 30000) begin
            tick();
            b++;
        end
        chk("wait_out", (((g == 0) ? log_d.size() : out_cnt[1]) >= n) ? 1 : 0, 1);
    endtask

    task automatic check_log(input string nm, input int nframes, input bit gapless);
        int exp_pat [16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
        chk({nm, "_count"}, log_d.size(), 16 * nframes);
        for (int k = 0; k < 16 * nframes && k < log_d.size(); k++) begin
            chk({nm, "_data"}, log_d[k], exp_pat[k % 16] + 4 * (k / 16));
            chk({nm, "_last"}, log_l[k], ((k % 16) == 15) ? 1 : 0);
        end
        if (gapless && log_d.size() >= 16 * nframes)
            chk({nm, "_gapless"}, log_t[16 * nframes - 1] - log_t[0], 16 * nframes - 1);
    endtask

    initial begin
        in_data[0] = '0;
        in_data[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_out_valid", out_valid[g], 0);
            chk("rst_out_last", out_last[g], 0);
            chk("rst_out_data", out_data[g], 0);
            chk("rst_in_ready", in_ready[g], 0);
        end
        tick();
        rst_v = 2'b00;
        @(negedge clk);
        chk("ready_after_rst_w2", in_ready[0], 1);
        chk("ready_after_rst_w4", in_ready[1], 1);
        tick();

        // Basic single frame, W=2
        log_d.delete(); log_l.delete(); log_t.delete();
        send_frame(0, 1, 4, 0);
        wait_out(0, 16);
        check_log("basic", 1, 1'b1);

        // Backpressure while the second copy of pixel 2 is held
        log_d.delete(); log_l.delete(); log_t.delete();
        fork
            send_frame(0, 1, 4, 0);
            begin
                int b = 0;
                do begin
                    @(negedge clk);
                    b++;
                end while (!(out_valid[0] && out_data[0] == 32'd2) && b < 200);
                chk("bp_found", (b < 200) ? 1 : 0, 1);
                hold_rdy[0] = 1'b0;
                @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", out_valid[0], 1);
                    chk("bp_data", out_data[0], 2);
                    chk("bp_in_ready", in_ready[0], 0);
                end
                hold_rdy[0] = 1'b1;
            end
        join
        wait_out(0, 16);
        check_log("backpressure", 1, 1'b0);

        // Two frames back-to-back
        log_d.delete(); log_l.delete(); log_t.delete();
        send_frame(0, 1, 8, 0);
        wait_out(0, 32);
        check_log("two_frames", 2, 1'b1);

        // Reset mid-frame, then a fresh frame
        log_d.delete(); log_l.delete(); log_t.delete();
        send_frame(0, 9, 2, 0);
        wait_out(0, 6);
        rst_v[0] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_out_last", out_last[0], 0);
        chk("midrst_in_ready", in_ready[0], 0);
        tick();
        rst_v[0] = 1'b0;
        log_d.delete(); log_l.delete(); log_t.delete();
        send_frame(0, 1, 4, 0);
        wait_out(0, 16);
        check_log("after_reset", 1, 1'b1);

        // Input gaps, W=4
        send_frame(1, 100, 16, 2);
        wait_out(1, 64);
        chk("gaps_lasts", n_last[1], 1);

        // Random in_valid gaps and out_ready, 50 more frames, W=4
        rnd_rdy[1] = 1'b1;
        for (int f = 0; f < 50; f++)
            for (int k = 0; k < 16; k++)
                send_px(1, $urandom, $urandom_range(0, 2));
        in_valid[1] = 1'b0;
        wait_out(1, 64 * 51);
        rnd_rdy[1] = 1'b0;
        repeat (4) tick();
        chk("rand_out_count", out_cnt[1], 64 * 51);
        chk("rand_last_count", n_last[1], 51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/upsample_stream.md
UPSAMPLE_STREAM -- requirements
Module: upsample_stream

Interface
REQ-001 Parameter WIDTH_IN, default 4, is the input frame side length in pixels; WIDTH_IN SHALL be at least 2.
REQ-002 Parameter WIDTH_OUT, default 2*WIDTH_IN, is the output frame side length and SHALL NOT be overridden.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid pixel.
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 in_data  input  32  input pixel; frames arrive in raster order, row-major, column index fastest.
REQ-008 out_valid  output  1  out_data holds a valid pixel.
REQ-009 out_ready  input  1  the downstream accepts out_data this cycle.
REQ-010 out_data  output  32  output pixel in raster order of the WIDTH_OUT x WIDTH_OUT frame.
REQ-011 out_last  output  1  qualifies the final pixel of an output frame; valid only while out_valid=1.

Function
REQ-012 The block SHALL perform 2x nearest-neighbour upsampling: output (r,c) = input (r/2, c/2), using integer division. This is the inverse-direction companion of the 2x2 average pool.
REQ-013 Pixel values SHALL pass through bit-exact, with no arithmetic applied.
REQ-014 An input transfer occurs when in_valid=1 and in_ready=1. An output transfer occurs when out_valid=1 and out_ready=1.
REQ-015 The output stage is a single register. It is "free" when out_valid=0 or out_ready=1. It SHALL load only when free.
REQ-016 While out_valid=1 and out_ready=0, out_data, out_valid and out_last SHALL hold stable.
REQ-017 The block SHALL contain a line buffer of WIDTH_IN x 32 bits. It SHALL also have:
  - counters col (0..WIDTH_IN-1) and row (0..WIDTH_IN-1);
  - a dup bit;
  - a two-state FSM {ROW_A, ROW_B}.
REQ-018 ROW_A behaviour:
  - in_ready = (dup=0) and output free.
  - On input transfer: write in_data to buf[col] and to the output register, then set dup=1.
REQ-019 ROW_A with dup=1 and output free: load buf[col] into the output register and set dup=0.
  - If col=WIDTH_IN-1: set col=0 and go to ROW_B.
  - Otherwise: increment col.
REQ-020 ROW_B behaviour:
  - in_ready=0.
  - Each cycle the output is free, load buf[col] and toggle dup.
  - When dup goes 1->0, advance col.
  - After col=WIDTH_IN-1 with dup=1 is emitted: set col=0.
  - If row=WIDTH_IN-1: set row=0 and return to ROW_A (frame wrap). Otherwise: increment row and return to ROW_A.
REQ-021 out_last SHALL be loaded as 1 exactly with the second copy of buf[WIDTH_IN-1] in ROW_B when row=WIDTH_IN-1. It SHALL be 0 for every other load.
REQ-022 Latency: a pixel accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-023 Throughput: given out_ready held at 1, the block SHALL emit one output pixel per cycle with no bubbles, except while waiting on in_valid in ROW_A.
REQ-024 In ROW_A with dup=0, if in_valid=0 and the output is free, out_valid SHALL drop to 0 after any pending transfer completes. No state SHALL advance.
REQ-025 The write to buf[col] and the read of buf[col] for the same column SHALL NOT occur in the same cycle. The second copy SHALL be read one or more cycles after the write.
REQ-026 Back-to-back frames SHALL stream without any idle cycle attributable to the frame wrap.

Reset
REQ-027 While reset=1, the following SHALL hold on the next edge: out_valid=0, out_last=0, out_data=0, in_ready=0, FSM=ROW_A, row=0, col=0, dup=0.
REQ-028 Line-buffer contents are not reset. They are don't-care until they are rewritten.
REQ-029 Reset asserted mid-frame SHALL abandon the partial frame. The first input accepted after reset SHALL be treated as input (0,0).
REQ-030 in_ready SHALL first be asserted in the cycle after reset deasserts.

Verification
REQ-031 Basic: WIDTH_IN=2, out_ready=1, input 1,2,3,4 back-to-back -> output 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 in 16 consecutive out_valid cycles, with out_last=1 only on the 16th.
REQ-032 Backpressure: drop out_ready to 0 for 5 cycles while out_data=2 -> out_data/out_valid hold 2 stable, in_ready=0, and the sequence resumes unchanged.
REQ-033 Input gaps: in_valid toggles 1,0,0,1 per pixel with WIDTH_IN=4 -> output sequence is identical to the gapless case and in_ready never rises during ROW_B.
REQ-034 Reset mid-frame: assert reset after the 6th output of a frame, then send 1..4 -> outputs restart at (0,0) with 1,1,2,2,... and out_last falls on the 16th output.
REQ-035 Two frames back-to-back, with inputs 1..4 then 5..8 and WIDTH_IN=2 -> 32 outputs, out_last on outputs 16 and 32, and the second frame starts 5,5,6,6.
REQ-036 Randomised: random in_valid/out_ready, WIDTH_IN=4, 50 frames -> a scoreboard matches REQ-012 for every pixel, and out_last is asserted exactly once per 64 outputs.
